// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dly_tap_ctrl.sv
// gf180mcu_fd_sc_mcu9t5v0__dly_tap_ctrl
// Walks the tap select of a delay chain one position at a time toward a
// requested tap. After each step it waits SETTLE cycles so the output mux
// switches cleanly. Completion is reported with a one-cycle ACK.
// Optional feature macro: GF180MCU_FD_SC_MCU9T5V0_DLY_TAP_CTRL_CLAMP_EN
//   defined   : an out-of-range CODE is clamped to NTAPS-1 and the move runs.
//   undefined : an out-of-range CODE is rejected and the tap is left unchanged.
// In both cases ERR pulses together with ACK.
module gf180mcu_fd_sc_mcu9t5v0__dly_tap_ctrl #(
  parameter int NTAPS     = 6,
  parameter int TW        = 3,
  parameter int SETTLE    = 4,
  parameter int RESET_TAP = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ,
  input  logic [TW-1:0]    CODE,
  output logic             ACK,
  output logic             BUSY,
  output logic             ERR,
  output logic [TW-1:0]    TAP,
  output logic [NTAPS-1:0] TAP_OH,
  inout  wire              VDD,
  inout  wire              VSS
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [TW-1:0]    r_target;
  logic [3:0]       r_cnt;
  logic             r_err_pend;
  logic             r_ack;
  logic             r_busy;
  logic             r_err;
  logic [TW-1:0]    r_tap;
  logic [NTAPS-1:0] r_tap_oh;

  logic             w_code_bad;
  logic [TW-1:0]    w_tgt;
  logic [TW-1:0]    w_step_tap;
  logic [NTAPS-1:0] w_step_oh;

  // Power pins carry no logic; gathered here only so they are referenced.
  wire w_unused_pwr = VDD ^ VSS;

  // The comparison is one bit wider so that NTAPS == 2**TW stays representable.
  assign w_code_bad = ({1'b0, CODE} >= (TW+1)'(NTAPS));

`ifdef GF180MCU_FD_SC_MCU9T5V0_DLY_TAP_CTRL_CLAMP_EN
  assign w_tgt = w_code_bad ? TW'(NTAPS - 1) : CODE;
`else
  // A rejected request targets the current tap, so it goes straight to DONE.
  assign w_tgt = w_code_bad ? r_tap : CODE;
`endif

  // Next tap is always one position toward the target, never more.
  assign w_step_tap = (r_target > r_tap) ? (r_tap + TW'(1)) : (r_tap - TW'(1));
  assign w_step_oh  = NTAPS'(1) << w_step_tap;

  // Control FSM: every output is a register updated here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_target   <= TW'(RESET_TAP);
      r_cnt      <= 4'd0;
      r_err_pend <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_tap      <= TW'(RESET_TAP);
      r_tap_oh   <= NTAPS'(1) << RESET_TAP;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= 1'b0;
          r_err <= 1'b0;
          if (REQ) begin
            r_busy     <= 1'b1;
            r_target   <= w_tgt;
            r_err_pend <= w_code_bad;
            r_state    <= (w_tgt == r_tap) ? S_DONE : S_STEP;
          end
        end
        S_STEP: begin
          r_tap    <= w_step_tap;
          r_tap_oh <= w_step_oh;
          r_cnt    <= 4'(SETTLE - 1);
          r_state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_cnt == 4'd0) begin
            r_state <= (r_tap == r_target) ? S_DONE : S_STEP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          // DONE lasts two cycles. The first cycle raises ACK. The second
          // cycle shows ACK and then drops ACK and BUSY together.
          if (!r_ack) begin
            r_ack <= 1'b1;
            r_err <= r_err_pend;
          end else begin
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_err_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ACK    = r_ack;
  assign BUSY   = r_busy;
  assign ERR    = r_err;
  assign TAP    = r_tap;
  assign TAP_OH = r_tap_oh;

endmodule
